// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial stage feeding a single-bit sequence detector. Words of
// WIDTH bits arrive over a valid/ready handshake and leave one bit per clock
// on ser_out. A one-word holding register lets the next word be taken while
// the current one is still shifting, so consecutive words come out with no
// idle cycle between them and patterns that straddle a word boundary stay
// intact.
//
// Parameters:
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT   level driven on ser_out when no frame is shifting
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_data      parallel word, sampled when in_valid && in_ready
//   in_valid     upstream offers a word
//   in_ready     combinational, high when the holding register is free and
//                the block is not in reset
//   ser_out      registered serial bit
//   ser_valid    registered, high while ser_out carries frame data
//   frame_start  registered pulse on the first bit of each word
//   frame_done   registered pulse on the last bit of each word
//   busy         high while shifting or while a word waits in the hold
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned     CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_IDX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   PENULT_IDX = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] shiftReg_q,   shiftReg_d;
    logic [WIDTH-1:0] holdReg_q,    holdReg_d;
    logic             holdFull_q,   holdFull_d;
    logic [CW-1:0]    bitCount_q,   bitCount_d;
    logic             serOut_q,     serOut_d;
    logic             serValid_q,   serValid_d;
    logic             frameStart_q, frameStart_d;
    logic             frameDone_q,  frameDone_d;

    logic             accept;
    logic             loadWord;
    logic [WIDTH-1:0] loadValue;

    // Bit that leaves first when a fresh word is placed in the shift register.
    function automatic logic firstBit(input logic [WIDTH-1:0] word);
        return MSB_FIRST ? word[WIDTH-1] : word[0];
    endfunction

    // The hold register is the only buffer beyond the word being shifted, so
    // a word can be taken whenever it is empty. Reset blocks the handshake so
    // nothing is accepted on an edge that is about to clear everything.
    assign in_ready = !holdFull_q && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == SHIFT) || holdFull_q;

    assign ser_out     = serOut_q;
    assign ser_valid   = serValid_q;
    assign frame_start = frameStart_q;
    assign frame_done  = frameDone_q;

    // Next-state logic. The registered serial outputs are computed one cycle
    // ahead: serOut_d is the bit that will be visible after this edge, and
    // bitCount_d is its index within the word. When the last bit is on the
    // wire the next word comes from the hold register first, otherwise
    // straight from in_data, so a queued word can never be skipped. A load
    // of the hold register only happens on non-last bits, which keeps
    // in_data from landing in both registers on the same edge.
    always_comb begin
        state_d      = state_q;
        shiftReg_d   = shiftReg_q;
        holdReg_d    = holdReg_q;
        holdFull_d   = holdFull_q;
        bitCount_d   = bitCount_q;
        serOut_d     = IDLE_BIT;
        serValid_d   = 1'b0;
        frameStart_d = 1'b0;
        frameDone_d  = 1'b0;
        loadWord     = 1'b0;
        loadValue    = in_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    loadWord  = 1'b1;
                    loadValue = in_data;
                end
            end
            SHIFT: begin
                if (bitCount_q != LAST_IDX) begin
                    shiftReg_d  = MSB_FIRST ? {shiftReg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shiftReg_q[WIDTH-1:1]};
                    serOut_d    = MSB_FIRST ? shiftReg_q[WIDTH-2] : shiftReg_q[1];
                    serValid_d  = 1'b1;
                    bitCount_d  = bitCount_q + 1'b1;
                    frameDone_d = (bitCount_q == PENULT_IDX);
                    if (accept) begin
                        holdReg_d  = in_data;
                        holdFull_d = 1'b1;
                    end
                end else if (holdFull_q) begin
                    loadWord   = 1'b1;
                    loadValue  = holdReg_q;
                    holdFull_d = 1'b0;
                end else if (accept) begin
                    loadWord  = 1'b1;
                    loadValue = in_data;
                end else begin
                    state_d    = IDLE;
                    bitCount_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (loadWord) begin
            state_d      = SHIFT;
            shiftReg_d   = loadValue;
            serOut_d     = firstBit(loadValue);
            serValid_d   = 1'b1;
            frameStart_d = 1'b1;
            bitCount_d   = '0;
        end
    end

    // State and output registers. Reset throws away both the word in flight
    // and any queued word, and returns the serial line to its idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shiftReg_q   <= '0;
            holdReg_q    <= '0;
            holdFull_q   <= 1'b0;
            bitCount_q   <= '0;
            serOut_q     <= IDLE_BIT;
            serValid_q   <= 1'b0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shiftReg_q   <= shiftReg_d;
            holdReg_q    <= holdReg_d;
            holdFull_q   <= holdFull_d;
            bitCount_q   <= bitCount_d;
            serOut_q     <= serOut_d;
            serValid_q   <= serValid_d;
            frameStart_q <= frameStart_d;
            frameDone_q  <= frameDone_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Drives an MSB-first and an LSB-first serializer with identical handshake
// traffic. Handshake timing does not depend on bit order, so both accept the
// same words on the same edges. The reference model keeps a queue of pending
// output beats: every accepted word appends WIDTH beats, each edge pops one
// beat onto the wire, and a word can be accepted while fewer than WIDTH beats
// are still waiting behind the one on the wire.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic [W-1:0] inData;

    logic readyMsb, serMsb, validMsb, startMsb, doneMsb, busyMsb;
    logic readyLsb, serLsb, validLsb, startLsb, doneLsb, busyLsb;

    typedef struct {
        bit serM;
        bit serL;
        bit start;
        bit done;
    } beat_t;

    beat_t  beatQ[$];
    bit     expSerM, expSerL, expValid, expStart, expDone;
    bit     modelReady;
    bit     lastAccept;
    int     checkCount;
    int     failCount;
    logic [7:0] capM, capL;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutMsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (inData),
        .in_valid   (inValid),
        .in_ready   (readyMsb),
        .ser_out    (serMsb),
        .ser_valid  (validMsb),
        .frame_start(startMsb),
        .frame_done (doneMsb),
        .busy       (busyMsb)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutLsb (
        .clk        (clk),
        .rst        (rst),
        .in_data    (inData),
        .in_valid   (inValid),
        .in_ready   (readyLsb),
        .ser_out    (serLsb),
        .ser_valid  (validLsb),
        .frame_start(startLsb),
        .frame_done (doneLsb),
        .busy       (busyLsb)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Reference model update for one rising edge.
    task automatic modelEdge(input bit rstV, input bit acc, input logic [W-1:0] word);
        beat_t b;
        if (rstV) begin
            beatQ.delete();
        end else if (acc) begin
            for (int i = 0; i < W; i++) begin
                b.serM  = word[W-1-i];
                b.serL  = word[i];
                b.start = (i == 0);
                b.done  = (i == W - 1);
                beatQ.push_back(b);
            end
        end
        if (!rstV && beatQ.size() > 0) begin
            b        = beatQ.pop_front();
            expSerM  = b.serM;
            expSerL  = b.serL;
            expValid = 1'b1;
            expStart = b.start;
            expDone  = b.done;
        end else begin
            expSerM  = 1'b0;
            expSerL  = 1'b0;
            expValid = 1'b0;
            expStart = 1'b0;
            expDone  = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check every
    // output mid-cycle, then advance the model on the rising edge.
    task automatic applyStimulus(input bit rstV, input bit validV, input logic [W-1:0] dataV);
        rst     = rstV;
        inValid = validV;
        inData  = dataV;
        #1;
        modelReady = !rstV && (beatQ.size() < W);
        checkOutput("in_ready msb",    32'(readyMsb), 32'(modelReady));
        checkOutput("in_ready lsb",    32'(readyLsb), 32'(modelReady));
        checkOutput("ser_out msb",     32'(serMsb),   32'(expSerM));
        checkOutput("ser_out lsb",     32'(serLsb),   32'(expSerL));
        checkOutput("ser_valid msb",   32'(validMsb), 32'(expValid));
        checkOutput("ser_valid lsb",   32'(validLsb), 32'(expValid));
        checkOutput("frame_start msb", 32'(startMsb), 32'(expStart));
        checkOutput("frame_start lsb", 32'(startLsb), 32'(expStart));
        checkOutput("frame_done msb",  32'(doneMsb),  32'(expDone));
        checkOutput("frame_done lsb",  32'(doneLsb),  32'(expDone));
        checkOutput("busy msb",        32'(busyMsb),  32'(expValid));
        checkOutput("busy lsb",        32'(busyLsb),  32'(expValid));
        if (expValid) begin
            capM = {capM[6:0], serMsb};
            capL = {capL[6:0], serLsb};
        end
        @(posedge clk);
        lastAccept = validV && modelReady;
        modelEdge(rstV, lastAccept, dataV);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
    endtask

    initial begin
        bit           haveWord;
        bit           pendReady;
        bit           doReset;
        logic [W-1:0] word;
        logic [W-1:0] dataV;

        checkCount = 0;
        failCount  = 0;
        rst        = 1'b1;
        inValid    = 1'b0;
        inData     = '0;
        capM       = '0;
        capL       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelEdge(1'b1, 1'b0, '0);

        // Reset state, with reset still asserted
        applyStimulus(1'b1, 1'b1, 8'h5A);
        applyStimulus(1'b1, 1'b0, '0);

        // Single word from idle, both bit orders
        capM = '0;
        capL = '0;
        applyStimulus(1'b0, 1'b1, 8'hD0);
        idleCycles(9);
        checkOutput("single word msb stream", 32'(capM), 32'h0000_00D0);
        checkOutput("single word lsb stream", 32'(capL), 32'h0000_000B);

        // Back-to-back words through the hold register
        applyStimulus(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h3C);
            if (lastAccept) break;
        end
        idleCycles(18);

        // Direct reload on the last bit with the hold empty
        applyStimulus(1'b0, 1'b1, 8'hFF);
        idleCycles(7);
        applyStimulus(1'b0, 1'b1, 8'h00);
        idleCycles(10);

        // Reset in the middle of a frame, then a fresh word
        applyStimulus(1'b0, 1'b1, 8'hD0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, '0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 8'h5A);
        idleCycles(10);

        // Backpressure with changing data while the hold is full
        applyStimulus(1'b0, 1'b1, 8'h77);
        applyStimulus(1'b0, 1'b1, 8'h99);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 8'h11 : 8'h22);
            if (lastAccept) break;
        end
        idleCycles(20);

        // Random traffic with occasional resets and data churn while stalled
        haveWord = 1'b0;
        word     = '0;
        for (int i = 0; i < 1500; i++) begin
            doReset = ($urandom_range(0, 199) == 0);
            if (!haveWord && $urandom_range(0, 99) < 70) begin
                haveWord = 1'b1;
                word     = W'($urandom());
            end
            pendReady = !doReset && (beatQ.size() < W);
            dataV     = (haveWord && pendReady) ? word : W'($urandom());
            applyStimulus(doReset, haveWord, dataV);
            if (lastAccept) haveWord = 1'b0;
        end
        idleCycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
